// File: rtl/sdram_bus_arbiter_if.sv
// sdram_bus_arbiter_if: request/grant bus between NPORT requesters, the arbiter and sdram_ctrl.
// slave modport is the arbiter's view; master modport is the requesters plus sdram_ctrl.
// m_* : per-port write/read request, address, data and grant, plus broadcast read data.
// s_* : single downstream write/read request, address, data and grant, plus read data.
interface sdram_bus_arbiter_if #(
  parameter int NPORT = 2,
  parameter int AW    = 24,
  parameter int DW    = 16
);
  logic [NPORT-1:0]    m_wreq;
  logic [NPORT-1:0]    m_wgnt;
  logic [NPORT*AW-1:0] m_waddr;
  logic [NPORT*DW-1:0] m_wdata;
  logic [NPORT-1:0]    m_rreq;
  logic [NPORT-1:0]    m_rgnt;
  logic [NPORT*AW-1:0] m_raddr;
  logic [DW-1:0]       m_rdata;
  logic                s_wreq;
  logic                s_wgnt;
  logic [AW-1:0]       s_waddr;
  logic [DW-1:0]       s_wdata;
  logic                s_rreq;
  logic                s_rgnt;
  logic [AW-1:0]       s_raddr;
  logic [DW-1:0]       s_rdata;
  modport slave (
    input  m_wreq, m_waddr, m_wdata, m_rreq, m_raddr, s_wgnt, s_rgnt, s_rdata,
    output m_wgnt, m_rgnt, m_rdata, s_wreq, s_waddr, s_wdata, s_rreq, s_raddr
  );
  modport master (
    output m_wreq, m_waddr, m_wdata, m_rreq, m_raddr, s_wgnt, s_rgnt, s_rdata,
    input  m_wgnt, m_rgnt, m_rdata, s_wreq, s_waddr, s_wdata, s_rreq, s_raddr
  );
endinterface

// File: rtl/sdram_bus_arbiter.sv
// sdram_bus_arbiter: shares one sdram_ctrl request bus between NPORT requesters, one transaction at a time.
// Ports: clk, rst_n (async active-low), bus (sdram_bus_arbiter_if.slave), busy (transaction in flight),
// owner (current or last owning port).
// Round-robin by default; define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module sdram_bus_arbiter #(
  parameter int NPORT = 2,
  parameter int AW    = 24,
  parameter int DW    = 16,
  localparam int OW   = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_bus_arbiter_if.slave   bus,
  output logic                 busy,
  output logic [OW-1:0]        owner
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic is_wr;
  logic found;
  logic [OW-1:0] win;
  logic [NPORT-1:0] elig;
  logic held;
  logic hit;
  assign elig = bus.m_wreq | bus.m_rreq;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // Scanning downward lets the lowest eligible index overwrite the rest.
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = NPORT - 1; k >= 0; k--)
      if (elig[k]) begin
        found = 1'b1;
        win = OW'(k);
      end
  end
`else
  logic [OW-1:0] ptr;
  // Scanning offsets downward lets the eligible port closest to ptr win.
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = NPORT - 1; k >= 0; k--)
      if (elig[(int'(ptr) + k) % NPORT]) begin
        found = 1'b1;
        win = OW'((int'(ptr) + k) % NPORT);
      end
  end
`endif
  assign held = is_wr ? bus.m_wreq[owner] : bus.m_rreq[owner];
  assign hit = busy && (is_wr ? bus.s_wgnt : bus.s_rgnt);
  assign bus.m_rdata = bus.s_rdata;
  // Grant is routed back combinationally so the owner sees it in the downstream grant cycle.
  always_comb begin
    bus.m_wgnt = '0;
    bus.m_rgnt = '0;
    if (busy && is_wr && bus.s_wgnt) bus.m_wgnt[owner] = 1'b1;
    if (busy && !is_wr && bus.s_rgnt) bus.m_rgnt[owner] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      owner <= '0;
      is_wr <= 1'b0;
      bus.s_wreq <= 1'b0;
      bus.s_rreq <= 1'b0;
      bus.s_waddr <= '0;
      bus.s_wdata <= '0;
      bus.s_raddr <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr <= '0;
`endif
    end else if (state == IDLE) begin
      if (found) begin
        state <= BUSY;
        busy <= 1'b1;
        owner <= win;
        is_wr <= bus.m_wreq[win];
        if (bus.m_wreq[win]) begin
          bus.s_wreq <= 1'b1;
          bus.s_waddr <= bus.m_waddr[win*AW +: AW];
          bus.s_wdata <= bus.m_wdata[win*DW +: DW];
        end else begin
          bus.s_rreq <= 1'b1;
          bus.s_raddr <= bus.m_raddr[win*AW +: AW];
        end
      end
    end else if (hit || !held) begin
      // Completion or abort; only a completed grant advances the pointer.
      state <= IDLE;
      busy <= 1'b0;
      bus.s_wreq <= 1'b0;
      bus.s_rreq <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      if (hit) ptr <= (int'(owner) == NPORT - 1) ? '0 : owner + 1'b1;
`endif
    end
  end
endmodule

// File: doc/sdram_bus_arbiter.md
Name: sdram_bus_arbiter

Overview:
- Shares the single sdram_ctrl request bus (wreq/wgnt/waddr/wdata, rreq/rgnt/raddr/rdata) between NPORT requesters, e.g. debug_uart plus a DMA or video engine.
- Sits between the requesters and sdram_ctrl.
- Grants one transaction at a time, round-robin across ports.
- Forwards exactly one write or read downstream, then routes the grant and read data back to the owner.

Parameters:
- NPORT, 2, number of requester ports (2..8).
- AW, 24, address width, matching sdram_ctrl.
- DW, 16, data width, matching sdram_ctrl.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- m_wreq  in  NPORT  per-port write request.
- m_wgnt  out  NPORT  per-port write grant.
- m_waddr  in  NPORT*AW  per-port write address; port i at bits [i*AW +: AW].
- m_wdata  in  NPORT*DW  per-port write data.
- m_rreq  in  NPORT  per-port read request.
- m_rgnt  out  NPORT  per-port read grant.
- m_raddr  in  NPORT*AW  per-port read address.
- m_rdata  out  DW  read data, broadcast to all ports; valid only with that port's m_rgnt.
- s_wreq  out  1  write request to sdram_ctrl.
- s_wgnt  in  1  write grant from sdram_ctrl.
- s_waddr  out  AW  write address to sdram_ctrl.
- s_wdata  out  DW  write data to sdram_ctrl.
- s_rreq  out  1  read request to sdram_ctrl.
- s_rgnt  in  1  read grant from sdram_ctrl.
- s_raddr  out  AW  read address to sdram_ctrl.
- s_rdata  in  DW  read data from sdram_ctrl; valid in the s_rgnt cycle.
- busy  out  1  transaction in flight.
- owner  out  max(1,$clog2(NPORT))  index of the current or last owner.

Behaviour:
- Reset values (asynchronous, active-low): s_wreq=0, s_rreq=0, s_waddr=0, s_wdata=0, s_raddr=0, busy=0, owner=0, round-robin pointer=0, state=IDLE. m_wgnt and m_rgnt are 0 whenever busy=0.
- Requester rule: hold req, addr and data stable until the matching gnt. One transaction per gnt cycle.
- IDLE state:
  - A port is eligible if m_wreq[i] or m_rreq[i] is set.
  - The winner is the first eligible port at or after the pointer, wrapping NPORT-1 to 0.
  - On the clock edge: state->BUSY, busy=1, owner=winner.
  - Op is latched: write if m_wreq[winner], else read. Write has priority when both are set on one port.
  - Owner's address/data are registered into s_waddr/s_wdata or s_raddr, and the matching s_*req is set to 1.
  - Latency: requester req in cycle N -> s_*req high in cycle N+1.
- BUSY state:
  - s_*req is held.
  - When the matching downstream grant arrives (s_wgnt for a write, s_rgnt for a read), m_*gnt[owner]=1 in the same cycle, combinationally.
  - On a read grant, m_rdata=s_rdata in that cycle, so READ_IMM capture works.
  - At that edge: s_*req=0, busy=0, pointer=owner+1 mod NPORT, state->IDLE.
  - Throughput: minimum 2 cycles per transaction. owner keeps its last value in IDLE.
- Abort: if the owner drops the latched-op request in BUSY with no grant that cycle, then at the next edge s_*req=0, state->IDLE, pointer unchanged, no m_*gnt. If grant and drop coincide, the grant wins and completes normally.
- Ignored grants: a downstream grant of the wrong op, or any grant in IDLE, is ignored; no m_*gnt.
- s_wreq and s_rreq are never both 1.
- Reset mid-transaction: outputs go to reset values immediately; the transaction is dropped.
- Other ports' requests are never lost; they wait in IDLE arbitration.

Optional Feature:
- Macro SDRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; pointer logic removed. Port 0 can starve the others.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: rst_n=0 asserted mid-BUSY -> s_wreq=s_rreq=0, busy=0, owner=0 immediately; no m_*gnt.
- Single write: port1 m_wreq, addr 0x000123, data 0xBEEF, s_wgnt 3 cycles later -> s_wreq high 1 cycle after req; s_waddr=0x000123, s_wdata=0xBEEF; m_wgnt[1] pulses 1 cycle coincident with s_wgnt; s_wreq low next cycle.
- Read routing: port0 read at 0x00ABCD, s_rgnt with s_rdata=0x1234 -> m_rgnt[0]=1 and m_rdata=0x1234 in the same cycle; m_rgnt[1]=0.
- Round-robin: ports 0 and 1 both request continuously, 4 transactions -> owner sequence 0,1,0,1. With SDRAM_ARB_FIXED_PRIO_EN -> 0,0,0,0.
- Same-port write+read: port0 m_wreq and m_rreq together -> write serviced first, read next; never both s_*req high.
- Abort and spurious grant: port1 drops m_rreq in BUSY before s_rgnt -> IDLE, no m_rgnt, pointer still 1. s_wgnt pulse while IDLE -> no m_wgnt.
